// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//
// Decodes the RV subset (R-type, ld, sd, beq, addi) in ID and carries the
// control bundle through registered EX, MEM and WB slots. Generates the
// load-use stall, the taken-branch flush and a one-cycle illegal-opcode pulse,
// and keeps saturating stall/flush event counters.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid, id_opcode             ID-stage instruction presence and opcode
//   id_rs1, id_rs2, id_rd           ID-stage register indices
//   ex_branch_taken                 EX comparator result for the EX instruction
//   stall_id, flush                 combinational hazard controls
//   illegal_op                      registered pulse on an unrecognised opcode
//   ex_*, mem_*, wb_*               per-stage control bundles
//   stall_count, flush_count        saturating event counters
module pipelined_control_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned HAZARD_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  output logic                  stall_id,
  output logic                  flush,
  output logic                  illegal_op,
  output logic                  ex_valid,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_mem_to_reg,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpLd   = 7'b0000011;
  localparam logic [6:0] OpSd   = 7'b0100011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpAddi = 7'b0010011;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic                  valid;
    ctrl_t                 ctrl;
    logic [REG_ADDR_W-1:0] rd;
  } slot_t;

  localparam slot_t Bubble = '0;

  ctrl_t dec_ctrl;
  logic  dec_legal;
  logic  dec_uses_rs2;

  slot_t ex_d, ex_q, mem_q, wb_q;
  logic  illegal_d, illegal_q;
  logic  hazard_raw;
  logic  [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Opcode decode: anything outside the table yields an all-zero bundle.
  always_comb begin
    dec_ctrl     = '0;
    dec_legal    = 1'b0;
    dec_uses_rs2 = 1'b0;
    case (id_opcode)
      OpR: begin
        dec_ctrl     = '{alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b1, mem_read: 1'b0,
                         mem_write: 1'b0, branch: 1'b0, alu_op: 2'b10};
        dec_legal    = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OpLd: begin
        dec_ctrl  = '{alu_src: 1'b1, mem_to_reg: 1'b1, reg_write: 1'b1, mem_read: 1'b1,
                      mem_write: 1'b0, branch: 1'b0, alu_op: 2'b00};
        dec_legal = 1'b1;
      end
      OpSd: begin
        dec_ctrl     = '{alu_src: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b0, mem_read: 1'b0,
                         mem_write: 1'b1, branch: 1'b0, alu_op: 2'b00};
        dec_legal    = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OpBeq: begin
        dec_ctrl     = '{alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0, mem_read: 1'b0,
                         mem_write: 1'b0, branch: 1'b1, alu_op: 2'b01};
        dec_legal    = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OpAddi: begin
        dec_ctrl  = '{alu_src: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b1, mem_read: 1'b0,
                      mem_write: 1'b0, branch: 1'b0, alu_op: 2'b00};
        dec_legal = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazards are purely combinational from ID inputs and EX state.
  always_comb begin
    flush      = ex_q.valid & ex_q.ctrl.branch & ex_branch_taken;
    hazard_raw = (HAZARD_EN != 0) & id_valid & dec_legal & ex_q.valid & ex_q.ctrl.mem_read &
                 (ex_q.rd != '0) &
                 ((ex_q.rd == id_rs1) | (dec_uses_rs2 & (ex_q.rd == id_rs2)));
    // A redirect makes the held instruction moot, so flush overrides stall.
    stall_id   = hazard_raw & ~flush;
  end

  always_comb begin
    ex_d = Bubble;
    if (!flush && !stall_id && id_valid && dec_legal) begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = dec_ctrl;
      ex_d.rd    = id_rd;
    end
    illegal_d = id_valid & ~dec_legal & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= Bubble;
      mem_q       <= Bubble;
      wb_q        <= Bubble;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      illegal_q <= illegal_d;
      if (stall_id && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign illegal_op     = illegal_q;
  assign ex_valid       = ex_q.valid;
  assign ex_alu_op      = ex_q.ctrl.alu_op;
  assign ex_alu_src     = ex_q.ctrl.alu_src;
  assign ex_branch      = ex_q.ctrl.branch;
  assign ex_mem_read    = ex_q.ctrl.mem_read;
  assign ex_mem_write   = ex_q.ctrl.mem_write;
  assign ex_mem_to_reg  = ex_q.ctrl.mem_to_reg;
  assign ex_reg_write   = ex_q.ctrl.reg_write;
  assign ex_rd          = ex_q.rd;
  assign mem_valid      = mem_q.valid;
  assign mem_mem_read   = mem_q.ctrl.mem_read;
  assign mem_mem_write  = mem_q.ctrl.mem_write;
  assign mem_mem_to_reg = mem_q.ctrl.mem_to_reg;
  assign mem_reg_write  = mem_q.ctrl.reg_write;
  assign mem_rd         = mem_q.rd;
  assign wb_valid       = wb_q.valid;
  assign wb_mem_to_reg  = wb_q.ctrl.mem_to_reg;
  assign wb_reg_write   = wb_q.ctrl.reg_write;
  assign wb_rd          = wb_q.rd;
  assign stall_count    = stall_cnt_q;
  assign flush_count    = flush_cnt_q;

endmodule
